// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and sizing for the DMA bus arbiter: FSM state encoding,
// bus widths and the default pipeline drain length.
package dma_arb_pkg;

   localparam int unsigned DRAIN_CYCLES_DEF = 3;
   localparam int unsigned ADDR_W           = 16;
   localparam int unsigned BEAT_W           = 8;
   localparam int unsigned DATA_W           = 8;
   localparam int unsigned DRAIN_W          = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      WR_WAIT = 3'd2,
      WR_LOAD = 3'd3,
      RD      = 3'd4,
      RELEASE = 3'd5
   } state_t;

   function automatic logic is_grant_state(input state_t s);
      return (s == WR_WAIT) || (s == WR_LOAD) || (s == RD);
   endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Requester, pipeline and memory-bus signals of the DMA arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface dma_bus_arbiter_if;
   import dma_arb_pkg::*;

   logic              req;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [BEAT_W-1:0] req_len;
   logic [DATA_W-1:0] wdata;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              bus_busy;
   logic              fetch_suppress;
   logic              grant;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_addr_en;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_dir;
   logic              mem_load;
   logic [DATA_W-1:0] mem_rdata;
   logic              done;

   modport slave (
      input  req, req_write, req_addr, req_len, wdata, wvalid, bus_busy, mem_rdata,
      output wready, rdata, rvalid, fetch_suppress, grant, mem_addr, mem_addr_en,
             mem_wdata, mem_dir, mem_load, done
   );

   modport master (
      output req, req_write, req_addr, req_len, wdata, wvalid, bus_busy, mem_rdata,
      input  wready, rdata, rvalid, fetch_suppress, grant, mem_addr, mem_addr_en,
             mem_wdata, mem_dir, mem_load, done
   );

endinterface

// File: rtl/dma_bus_arbiter_xfer_counter.sv
// Burst bookkeeping: wrapping 16-bit beat address and remaining-beat
// down counter; last flags the beat that ends the burst.
module dma_xfer_counter
   import dma_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [BEAT_W-1:0] start_len,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] addr_r;
   logic [BEAT_W-1:0] remain_r;

   // Address and remaining-beat registers; address wraps modulo 2^16.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r   <= {ADDR_W{1'b0}};
         remain_r <= {BEAT_W{1'b0}};
      end else if (load) begin
         addr_r   <= start_addr;
         remain_r <= start_len;
      end else if (step) begin
         addr_r   <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         remain_r <= remain_r - {{(BEAT_W-1){1'b0}}, 1'b1};
      end else begin
         addr_r   <= addr_r;
         remain_r <= remain_r;
      end
   end

   assign addr = addr_r;
   assign last = (remain_r == {BEAT_W{1'b0}});

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the CPU memory path to a block-transfer requester: suppresses fetch,
// waits for the pipeline to drain, runs a 1..256 beat burst, returns the bus.
module dma_bus_arbiter
   import dma_arb_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             MAINCLK,
   input  logic             MAINRST,
   dma_bus_arbiter_if.slave bus
);

   state_t              state_r;
   state_t              state_next;
   logic [DRAIN_W-1:0]  drain_cnt_r;
   logic                armed_r;
   logic                write_r;
   logic                ctr_load_s;
   logic                ctr_step_s;
   logic                ctr_last_s;
   logic                drain_dec_s;
   logic                wcap_s;
   logic                rd_beat_s;
   logic [ADDR_W-1:0]   addr_s;

   logic                fetch_suppress_r;
   logic                grant_r;
   logic                wready_r;
   logic                mem_dir_r;
   logic                mem_load_r;
   logic                done_r;
   logic                rvalid_r;
   logic [DATA_W-1:0]   rdata_r;
   logic [DATA_W-1:0]   mem_wdata_r;

   dma_xfer_counter u_xfer_counter (
      .clk        (MAINCLK),
      .rst_n      (MAINRST),
      .load       (ctr_load_s),
      .step       (ctr_step_s),
      .start_addr (bus.req_addr),
      .start_len  (bus.req_len),
      .addr       (addr_s),
      .last       (ctr_last_s)
   );

   // State register.
   always_ff @(posedge MAINCLK or negedge MAINRST) begin
      if (!MAINRST) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state decode and per-cycle datapath strobes.
   always_comb begin
      state_next  = state_r;
      ctr_load_s  = 1'b0;
      ctr_step_s  = 1'b0;
      drain_dec_s = 1'b0;
      wcap_s      = 1'b0;
      rd_beat_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req && armed_r) begin
               state_next = DRAIN;
               ctr_load_s = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (!bus.req) begin
               state_next = IDLE;
            end else if (drain_cnt_r != {DRAIN_W{1'b0}}) begin
               drain_dec_s = 1'b1;
            end else if (!bus.bus_busy) begin
               state_next = write_r ? WR_WAIT : RD;
            end else begin
               state_next = DRAIN;
            end
         end
         WR_WAIT: begin
            if (!bus.req) begin
               state_next = RELEASE;
            end else if (bus.wvalid) begin
               state_next = WR_LOAD;
               wcap_s     = 1'b1;
            end else begin
               state_next = WR_WAIT;
            end
         end
         WR_LOAD: begin
            ctr_step_s = 1'b1;
            if (ctr_last_s || !bus.req) begin
               state_next = RELEASE;
            end else begin
               state_next = WR_WAIT;
            end
         end
         RD: begin
            ctr_step_s = 1'b1;
            rd_beat_s  = 1'b1;
            if (ctr_last_s || !bus.req) begin
               state_next = RELEASE;
            end else begin
               state_next = RD;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Acceptance bookkeeping: direction, drain countdown and re-arm flag.
   // armed only returns once req has been seen low in IDLE.
   always_ff @(posedge MAINCLK or negedge MAINRST) begin
      if (!MAINRST) begin
         write_r     <= 1'b0;
         drain_cnt_r <= {DRAIN_W{1'b0}};
         armed_r     <= 1'b1;
      end else if (ctr_load_s) begin
         write_r     <= bus.req_write;
         drain_cnt_r <= DRAIN_W'(DRAIN_CYCLES - 32'd1);
         armed_r     <= 1'b0;
      end else begin
         write_r     <= write_r;
         drain_cnt_r <= drain_dec_s ? (drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1}) : drain_cnt_r;
         armed_r     <= ((state_r == IDLE) && !bus.req) ? 1'b1 : armed_r;
      end
   end

   // Outputs registered from the state being entered so they line up with it.
   always_ff @(posedge MAINCLK or negedge MAINRST) begin
      if (!MAINRST) begin
         fetch_suppress_r <= 1'b0;
         grant_r          <= 1'b0;
         wready_r         <= 1'b0;
         mem_dir_r        <= 1'b0;
         mem_load_r       <= 1'b0;
         done_r           <= 1'b0;
         rvalid_r         <= 1'b0;
         rdata_r          <= {DATA_W{1'b0}};
         mem_wdata_r      <= {DATA_W{1'b0}};
      end else begin
         fetch_suppress_r <= (state_next != IDLE);
         grant_r          <= is_grant_state(state_next);
         wready_r         <= (state_next == WR_WAIT);
         mem_dir_r        <= (state_next == WR_LOAD);
         mem_load_r       <= (state_next == WR_LOAD);
         done_r           <= (state_next == RELEASE);
         rvalid_r         <= rd_beat_s;
         rdata_r          <= rd_beat_s ? bus.mem_rdata : rdata_r;
         mem_wdata_r      <= wcap_s ? bus.wdata : mem_wdata_r;
      end
   end

   assign bus.fetch_suppress = fetch_suppress_r;
   assign bus.grant          = grant_r;
   assign bus.mem_addr_en    = grant_r;
   assign bus.mem_addr       = addr_s;
   assign bus.wready         = wready_r;
   assign bus.mem_dir        = mem_dir_r;
   assign bus.mem_load       = mem_load_r;
   assign bus.mem_wdata      = mem_wdata_r;
   assign bus.done           = done_r;
   assign bus.rvalid         = rvalid_r;
   assign bus.rdata          = rdata_r;

endmodule
